// File: rtl/i2c_slave_regfile.sv
// I2C target with a small byte register file: oversampled SCL/SDA, open-drain SDA
// through an output-enable, local write-notify pulse and a combinational local read port.
`timescale 1ns/1ps
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h5D,
  parameter int         NUM_REGS = 16,
  parameter int         AW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] loc_addr,
  output logic [7:0]    loc_data
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEV_ADDR = 4'd1,
    ST_ACK_DEV  = 4'd2,
    ST_REG_ADDR = 4'd3,
    ST_ACK_REG  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_ACK_WR   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8
  } state_t;

  state_t          state_r;
  logic [3:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic [AW-1:0]   ptr_r;
  logic            rw_r;
  logic            ack_ph_r;
  logic            rd_first_r;
  logic [7:0]      regs_r [NUM_REGS];

  logic            scl_s1_r, scl_s2_r, scl_h_r;
  logic            sda_s1_r, sda_s2_r, sda_h_r;

  logic            scl_rise_s;
  logic            scl_fall_s;
  logic            start_s;
  logic            stop_s;
  logic [7:0]      byte_in_s;
  logic [AW-1:0]   ptr_inc_s;

  // Two-flop synchronizers plus one history stage; reset to the idle (high) bus level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1_r <= 1'b1;
      scl_s2_r <= 1'b1;
      scl_h_r  <= 1'b1;
      sda_s1_r <= 1'b1;
      sda_s2_r <= 1'b1;
      sda_h_r  <= 1'b1;
    end else begin
      scl_s1_r <= scl_i;
      scl_s2_r <= scl_s1_r;
      scl_h_r  <= scl_s2_r;
      sda_s1_r <= sda_i;
      sda_s2_r <= sda_s1_r;
      sda_h_r  <= sda_s2_r;
    end
  end

  assign scl_rise_s = scl_s2_r & ~scl_h_r;
  assign scl_fall_s = ~scl_s2_r & scl_h_r;
  assign start_s    = scl_s2_r & scl_h_r & sda_h_r & ~sda_s2_r;
  assign stop_s     = scl_s2_r & scl_h_r & ~sda_h_r & sda_s2_r;
  assign byte_in_s  = {shift_r[6:0], sda_s2_r};
  assign ptr_inc_s  = ptr_r + AW'(1);
  assign loc_data   = regs_r[loc_addr];

  // Protocol FSM, register file and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      ptr_r      <= {AW{1'b0}};
      rw_r       <= 1'b0;
      ack_ph_r   <= 1'b0;
      rd_first_r <= 1'b0;
      sda_oe     <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= {AW{1'b0}};
      wr_data    <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      // Bus conditions override any bit processing in the same cycle
      if (start_s) begin
        state_r   <= ST_DEV_ADDR;
        bit_cnt_r <= 4'd0;
        ack_ph_r  <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_s) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 4'd0;
        ack_ph_r  <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            sda_oe <= 1'b0;
          end
          ST_DEV_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= byte_in_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                ack_ph_r  <= 1'b0;
                if (byte_in_s[7:1] == DEV_ADDR) begin
                  rw_r    <= byte_in_s[0];
                  state_r <= ST_ACK_DEV;
                end else begin
                  state_r <= ST_IDLE;
                end
              end
            end
          end
          ST_REG_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= byte_in_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                ack_ph_r  <= 1'b0;
                ptr_r     <= byte_in_s[AW-1:0];
                state_r   <= ST_ACK_REG;
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise_s) begin
              shift_r   <= byte_in_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r     <= 4'd0;
                ack_ph_r      <= 1'b0;
                regs_r[ptr_r] <= byte_in_s;
                wr_valid      <= 1'b1;
                wr_addr       <= ptr_r;
                wr_data       <= byte_in_s;
                ptr_r         <= ptr_inc_s;
                state_r       <= ST_ACK_WR;
              end
            end
          end
          ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: begin
            // First falling edge pulls SDA low, the second ends the ACK slot
            if (scl_fall_s) begin
              if (!ack_ph_r) begin
                sda_oe   <= 1'b1;
                ack_ph_r <= 1'b1;
              end else begin
                ack_ph_r  <= 1'b0;
                bit_cnt_r <= 4'd0;
                if ((state_r == ST_ACK_DEV) && rw_r) begin
                  shift_r    <= regs_r[ptr_r];
                  sda_oe     <= ~regs_r[ptr_r][7];
                  rd_first_r <= 1'b0;
                  state_r    <= ST_RD_DATA;
                end else if (state_r == ST_ACK_DEV) begin
                  sda_oe  <= 1'b0;
                  state_r <= ST_REG_ADDR;
                end else begin
                  sda_oe  <= 1'b0;
                  state_r <= ST_WR_DATA;
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s) begin
              if (rd_first_r) begin
                sda_oe     <= ~shift_r[7];
                rd_first_r <= 1'b0;
              end else if (bit_cnt_r == 4'd8) begin
                sda_oe    <= 1'b0;
                bit_cnt_r <= 4'd0;
                state_r   <= ST_RD_ACK;
              end else begin
                sda_oe  <= ~shift_r[6];
                shift_r <= {shift_r[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise_s) begin
              if (!sda_s2_r) begin
                ptr_r      <= ptr_inc_s;
                shift_r    <= regs_r[ptr_inc_s];
                rd_first_r <= 1'b1;
                bit_cnt_r  <= 4'd0;
                state_r    <= ST_RD_DATA;
              end else begin
                state_r <= ST_IDLE;
              end
            end
          end
          default: begin
            sda_oe  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
